// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and instruction-fetch request controller.
// Walks the PC sequentially on accepted fetches. It redirects to a jump,
// branch or trap target and inserts one bubble cycle after every redirect.
// Optional feature macro: PC_TRAP_EN. It adds the trap input, which has the
// highest redirect priority and targets TRAP_VEC, and the epc output, which
// captures the PC of the trapping cycle.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        if_ready,
`ifdef PC_TRAP_EN
  input  logic        trap,
  output logic [31:0] epc,
`endif
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        if_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        trap_act;
  logic        redir_req;
  logic [31:0] redir_tgt;
  logic [31:0] pc_nxt;
  logic        fire;

`ifdef PC_TRAP_EN
  assign trap_act = trap;
`else
  // With no trap source, the trap path is tied off. It folds away, so the
  // priority mux stays the same in both builds.
  assign trap_act = 1'b0;
`endif

  assign PCPlus4  = PC + 32'd4;
  assign if_valid = (state == FETCH) && !stall;
  assign fire     = if_valid && if_ready;

  // Redirect selection: trap > jump > branch. Redirects are ignored in BOOT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    redir_req = 1'b0;
    redir_tgt = PC;
    if (state != BOOT) begin
      if (trap_act) begin
        redir_req = 1'b1;
        redir_tgt = TRAP_VEC;
      end else if (jump) begin
        redir_req = 1'b1;
        redir_tgt = jump_target;
      end else if (branch_taken) begin
        redir_req = 1'b1;
        redir_tgt = branch_target;
      end
    end
  end

  // Next state and next PC. A redirect wins over a fire. A stall or a refused
  // request leaves the PC where it is.
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    unique case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   state_nxt = redir_req ? REDIR : FETCH;
      REDIR:   state_nxt = redir_req ? REDIR : FETCH;
      default: state_nxt = BOOT;
    endcase
    if (redir_req) begin
      pc_nxt = {redir_tgt[31:2], 2'b00};
    end else if (fire) begin
      pc_nxt = PCPlus4;
    end
  end

  // State, PC and misalign flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      state    <= BOOT;
      PC       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      PC       <= pc_nxt;
      misalign <= redir_req && (redir_tgt[1:0] != 2'b00);
    end
  end

`ifdef PC_TRAP_EN
  // Exception PC: captures the PC of the cycle in which a trap is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc <= 32'h0000_0000;
    end else if (trap_act && (state != BOOT)) begin
      epc <= PC;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl. It compares the DUT every cycle against a
// cycle-level reference model of the fetch rules. Directed scenarios also
// check literal expected values.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        if_ready = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] PC, PCPlus4;
  logic        if_valid, misalign;
`ifdef PC_TRAP_EN
  logic [31:0] epc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: fetch address, "has left boot", "bubble pending", flag.
  logic [31:0] m_pc;
  bit          m_booted;
  bit          m_bubble;
  bit          m_mis;
`ifdef PC_TRAP_EN
  logic [31:0] m_epc;
`endif

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .if_ready(if_ready),
`ifdef PC_TRAP_EN
    .trap(trap),
    .epc(epc),
`endif
    .PC(PC),
    .PCPlus4(PCPlus4),
    .if_valid(if_valid),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_booted = 0;
    m_bubble = 0;
    m_mis    = 0;
`ifdef PC_TRAP_EN
    m_epc    = '0;
`endif
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; trap = 0; if_ready = 0;
  endtask

  // One clock cycle. The caller sets the inputs first. This task compares the
  // outputs with the model, crosses the edge, applies the fetch rules to the
  // model, and returns 1 ns after the edge.
  task automatic step(input string tag);
    bit          exp_valid;
    bit          redir;
    logic [31:0] tgt;
    #1;
    exp_valid = m_booted && !m_bubble && !stall;
    checks++;
    if (PC !== m_pc) begin
      errors++; $display("FAIL %s pc: got %h expected %h", tag, PC, m_pc);
    end
    checks++;
    if (PCPlus4 !== m_pc + 32'd4) begin
      errors++; $display("FAIL %s pcplus4: got %h expected %h", tag, PCPlus4, m_pc + 32'd4);
    end
    checks++;
    if (if_valid !== exp_valid) begin
      errors++; $display("FAIL %s if_valid: got %b expected %b", tag, if_valid, exp_valid);
    end
    checks++;
    if (misalign !== m_mis) begin
      errors++; $display("FAIL %s misalign: got %b expected %b", tag, misalign, m_mis);
    end
`ifdef PC_TRAP_EN
    checks++;
    if (epc !== m_epc) begin
      errors++; $display("FAIL %s epc: got %h expected %h", tag, epc, m_epc);
    end
`endif
    @(posedge clk);
    if (!m_booted) begin
      m_booted = 1;
      m_mis    = 0;
    end else begin
      redir = 1;
      tgt   = '0;
`ifdef PC_TRAP_EN
      if (trap) begin
        tgt = TRAP_VEC; m_epc = m_pc;
      end else
`endif
      if (jump) tgt = jump_target;
      else if (branch_taken) tgt = branch_target;
      else redir = 0;
      if (redir) begin
        m_pc     = tgt & 32'hFFFF_FFFC;
        m_mis    = (tgt % 4) != 0;
        m_bubble = 1;
      end else begin
        if (exp_valid && if_ready) m_pc = m_pc + 32'd4;
        m_bubble = 0;
        m_mis    = 0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (PC !== RESET_PC) begin
      errors++; $display("FAIL reset pc: got %h expected %h", PC, RESET_PC);
    end
    checks++;
    if (if_valid !== 1'b0 || misalign !== 1'b0) begin
      errors++; $display("FAIL reset flags: got valid=%b mis=%b expected 0 0", if_valid, misalign);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  // Reset release with if_ready held high: one idle cycle, then 0, 4, 8, C.
  // Ends in FETCH at PC = 0x10.
  task automatic test_sequential();
    if_ready = 1;
    step("boot");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (PC !== 32'(i * 4) || if_valid !== 1'b1) begin
        errors++; $display("FAIL seq%0d: got pc=%h valid=%b expected %h 1", i, PC, if_valid, i * 4);
      end
      step("seq");
    end
  endtask

  // Back-pressure: the request and its address stay put while if_ready is low.
  task automatic test_backpressure();
    if_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (PC !== 32'h10 || if_valid !== 1'b1) begin
        errors++; $display("FAIL hold%0d: got pc=%h valid=%b expected 00000010 1", i, PC, if_valid);
      end
      step("hold");
    end
    if_ready = 1;
    step("release");
    checks++;
    if (PC !== 32'h14) begin
      errors++; $display("FAIL bp_advance: got %h expected 00000014", PC);
    end
  endtask

  // Jump beats a simultaneous branch, and the redirect inserts one bubble.
  task automatic test_redirect_priority();
    if_ready = 1;
    jump = 1; jump_target = 32'h200;
    branch_taken = 1; branch_target = 32'h300;
    step("prio");
    jump = 0; branch_taken = 0;
    #1;
    checks++;
    if (PC !== 32'h200 || if_valid !== 1'b0) begin
      errors++; $display("FAIL prio_bubble: got pc=%h valid=%b expected 00000200 0", PC, if_valid);
    end
    step("bubble");
    checks++;
    if (PC !== 32'h200 || if_valid !== 1'b1) begin
      errors++; $display("FAIL prio_fetch0: got pc=%h valid=%b expected 00000200 1", PC, if_valid);
    end
    step("fetch200");
    checks++;
    if (PC !== 32'h204) begin
      errors++; $display("FAIL prio_fetch1: got %h expected 00000204", PC);
    end
  endtask

  // A misaligned branch target loads aligned and pulses misalign for one cycle.
  task automatic test_misalign();
    if_ready = 1;
    branch_taken = 1; branch_target = 32'h103;
    step("mis_req");
    branch_taken = 0;
    checks++;
    if (PC !== 32'h100 || misalign !== 1'b1) begin
      errors++; $display("FAIL mis_pulse: got pc=%h mis=%b expected 00000100 1", PC, misalign);
    end
    step("mis_bubble");
    checks++;
    if (misalign !== 1'b0) begin
      errors++; $display("FAIL mis_clear: got %b expected 0", misalign);
    end
  endtask

  // Fetching at the top address wraps the PC to 0, then a stall holds it.
  task automatic test_wrap_and_stall();
    if_ready = 1;
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step("wrap_jump");
    jump = 0;
    step("wrap_bubble");
    checks++;
    if (PCPlus4 !== 32'h0 || misalign !== 1'b0) begin
      errors++; $display("FAIL wrap_pcplus4: got %h mis=%b expected 00000000 0", PCPlus4, misalign);
    end
    step("wrap_fire");
    checks++;
    if (PC !== 32'h0) begin
      errors++; $display("FAIL wrap_pc: got %h expected 00000000", PC);
    end
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (if_valid !== 1'b0 || PC !== 32'h0) begin
        errors++; $display("FAIL stall%0d: got valid=%b pc=%h expected 0 00000000", i, if_valid, PC);
      end
      step("stall");
    end
    stall = 0;
  endtask

`ifdef PC_TRAP_EN
  // Trap beats jump and captures epc. Reset in REDIR aborts at once.
  task automatic test_trap();
    if_ready = 1;
    jump = 1; jump_target = 32'h40;
    step("to40");
    jump = 0;
    step("to40_bubble");
    trap = 1; jump = 1; jump_target = 32'h500;
    step("trap");
    trap = 0; jump = 0;
    checks++;
    if (PC !== TRAP_VEC || epc !== 32'h40) begin
      errors++; $display("FAIL trap: got pc=%h epc=%h expected %h 00000040", PC, epc, TRAP_VEC);
    end
    apply_reset();
    step("post_reset");
  endtask
`endif

  // Random traffic checked against the model, with occasional resets.
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      if_ready      = ($urandom_range(0, 2) != 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
`ifdef PC_TRAP_EN
      trap          = ($urandom_range(0, 19) == 0);
`endif
      if (i == 200 || i == 450) begin
        apply_reset();
      end else begin
        step("rand");
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_priority();
    test_misalign();
    test_wrap_and_stall();
`ifdef PC_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0080, is the trap target (used only with PC_TRAP_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  downstream not ready; hold PC, suppress fetch request.
REQ-006 branch_taken  input  1  redirect to branch_target this cycle.
REQ-007 branch_target  input  32  branch destination.
REQ-008 jump  input  1  redirect to jump_target this cycle.
REQ-009 jump_target  input  32  jump destination.
REQ-010 if_ready  input  1  instruction memory accepts the current fetch request.
REQ-011 PC  output  32  current fetch address, registered.
REQ-012 PCPlus4  output  32  PC+4, combinational from PC, modulo 2^32.
REQ-013 if_valid  output  1  fetch request valid for address PC.
REQ-014 misalign  output  1  one-cycle pulse; the accepted redirect target had bits[1:0] nonzero.

Function
REQ-015 States BOOT, FETCH, REDIR; BOOT entered on reset; BOOT->FETCH unconditionally after one clock.
REQ-016 if_valid = (state==FETCH) && !stall; 0 in BOOT and REDIR.
REQ-017 Fire = if_valid && if_ready; on fire with no redirect, PC <= PCPlus4 next edge.
REQ-018 While if_valid && !if_ready with no redirect, PC holds stable (no request withdrawal or address change).
REQ-019 Redirect priority: trap (if enabled) > jump > branch_taken; the highest active source is taken, others ignored that cycle.
REQ-020 Redirect accepted in any state except BOOT, regardless of stall or if_ready; PC <= target next edge; state -> REDIR.
REQ-021 REDIR lasts exactly one cycle (bubble, if_valid=0), then -> FETCH; a redirect in REDIR reloads PC and stays in REDIR one more cycle.
REQ-022 Redirect in BOOT is ignored.
REQ-023 Redirect target loaded with bits[1:0] forced to 2'b00; misalign=1 the following cycle iff the selected target's bits[1:0]!=0, else 0.
REQ-024 stall with no redirect: PC holds, state unchanged.
REQ-025 PC 32'hFFFF_FFFC: PCPlus4 = 32'h0000_0000; fire wraps PC to 0, no flag.

Reset
REQ-026 On rst_n low, immediately: PC=RESET_PC, state=BOOT, if_valid=0, misalign=0 (epc=0 when enabled).
REQ-027 Reset assertion mid-fetch or mid-REDIR aborts the operation; no pending redirect survives.
REQ-028 Release of rst_n takes effect at the first rising clk edge after deassertion; first fetch request at RESET_PC one cycle after release.

Configuration
REQ-029 Macro PC_TRAP_EN: when defined, adds input trap (1) and output epc (32); trap is highest-priority redirect to TRAP_VEC and epc <= PC of that cycle on the same edge.
REQ-030 Without PC_TRAP_EN, ports trap and epc do not exist and redirect sources are jump and branch_taken only.

Verification
REQ-031 Reset release, if_ready=1 constant -> if_valid 0 for one cycle, then PC sequence 0,4,8,C on consecutive cycles.
REQ-032 PC=0x10, if_ready=0 for 3 cycles -> PC stays 0x10, if_valid=1; if_ready=1 -> PC=0x14 next cycle.
REQ-033 jump=1 jump_target=0x200 and branch_taken=1 branch_target=0x300 same cycle -> PC=0x200, one bubble cycle, then fetch 0x200, 0x204.
REQ-034 branch_target=0x103 taken -> PC=0x100, misalign=1 for one cycle only.
REQ-035 PC=0xFFFF_FFFC fire -> PCPlus4=0, next PC=0; stall=1 for 2 cycles -> if_valid=0, PC unchanged.
REQ-036 PC_TRAP_EN defined: PC=0x40, trap and jump together -> PC=TRAP_VEC(0x80), epc=0x40; rst_n low mid-REDIR -> PC=RESET_PC immediately.
